// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit                                              |
// | Description : Memory-access stage sitting behind the ALU. Issues a single  |
// |               outstanding request/acknowledge transaction on the data      |
// |               memory / MMIO bus, holds the core while it is in flight, and |
// |               returns sign- or zero-extended load data to write-back.      |
// |                                                                            |
// | Ports       : clk, rst_n         - core clock, async active-low reset      |
// |               ALUResult          - effective address                       |
// |               ReadData2          - store data (rs2)                        |
// |               MemRead/MemWrite   - load / store request for this instr    |
// |               funct3             - access size and signedness             |
// |               stall              - hold PC/pipeline this cycle            |
// |               load_data/valid    - extended load result (DONE of a load)  |
// |               misaligned         - misaligned-access trap flag            |
// |               bus_err            - bus timeout flag (DONE only)           |
// |               bus_req/we/addr/wdata/wstrb, bus_rdata/ack - memory bus     |
// |                                                                            |
// | Options     : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word    |
// |               accesses are not issued and raise misaligned in DONE.        |
// |               When undefined, low address bits are truncated instead.    |
// |                                                                            |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           ALUResult,
  input  logic [31:0]           ReadData2,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  output logic                  stall,
  output logic [31:0]           load_data,
  output logic                  load_valid,
  output logic                  misaligned,
  output logic                  bus_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  output logic [3:0]            bus_wstrb,
  input  logic [31:0]           bus_rdata,
  input  logic                  bus_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit so
  // the disabled-timeout build still elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Registered state
  state_t                  state_q,      state_d;
  logic [CNT_W-1:0]        cnt_q,        cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
  logic [1:0]              lane_q,       lane_d;
  logic [1:0]              size_q,       size_d;
  logic                    unsigned_q,   unsigned_d;
  logic                    we_q,         we_d;
  logic [31:0]             wdata_q,      wdata_d;
  logic [3:0]              wstrb_q,      wstrb_d;
  logic [31:0]             load_data_q,  load_data_d;
  logic                    bus_err_q,    bus_err_d;
  logic                    misaligned_q, misaligned_d;

  // Request decode from the incoming instruction
  logic                    start;
  logic [1:0]              req_size;
  logic [1:0]              req_lane;
  logic                    req_unsigned;
  logic [3:0]              req_wstrb;
  logic [31:0]             req_wdata;
  logic                    req_misaligned;

  // Load path
  logic [31:0]             rdata_shifted;
  logic [31:0]             rdata_ext;
  logic                    timeout_hit;
  logic                    stall_c;

  assign start = MemRead | MemWrite;

  // Size/lane decode. Half uses the upper or lower halfword lane; word
  // always uses lane 0, which also truncates misaligned addresses when the
  // trap is not built in. Reserved encodings fall through to word.
  always_comb begin
    req_size     = SZ_WORD;
    req_lane     = 2'b00;
    req_wstrb    = 4'b1111;
    req_wdata    = ReadData2;
    req_unsigned = funct3[2] & ~funct3[1];
    if (!funct3[1]) begin
      if (funct3[0]) begin
        req_size  = SZ_HALF;
        req_lane  = {ALUResult[1], 1'b0};
        req_wstrb = 4'b0011 << req_lane;
        req_wdata = {2{ReadData2[15:0]}};
      end else begin
        req_size  = SZ_BYTE;
        req_lane  = ALUResult[1:0];
        req_wstrb = 4'b0001 << req_lane;
        req_wdata = {4{ReadData2[7:0]}};
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misaligned = ((req_size == SZ_HALF) && ALUResult[0]) ||
                          ((req_size == SZ_WORD) && (ALUResult[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  // Bring the addressed lane down to bit 0, then extend to 32 bits.
  assign rdata_shifted = bus_rdata >> {lane_q, 3'b000};

  always_comb begin
    rdata_ext = bus_rdata;
    case (size_q)
      SZ_BYTE: rdata_ext = unsigned_q ? {24'h0, rdata_shifted[7:0]}
                                      : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      SZ_HALF: rdata_ext = unsigned_q ? {16'h0, rdata_shifted[15:0]}
                                      : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: rdata_ext = bus_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    addr_d       = addr_q;
    lane_d       = lane_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    load_data_d  = load_data_q;
    bus_err_d    = 1'b0;
    misaligned_d = 1'b0;
    stall_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall_c = start;
        if (start) begin
          // A store wins if both MemRead and MemWrite are asserted.
          addr_d      = {ALUResult[ADDR_WIDTH-1:2], 2'b00};
          lane_d      = req_lane;
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          we_d        = MemWrite;
          wdata_d     = MemWrite ? req_wdata : 32'h0;
          wstrb_d     = MemWrite ? req_wstrb : 4'h0;
          load_data_d = 32'h0;
          if (req_misaligned) begin
            misaligned_d = 1'b1;
            state_d      = ST_DONE;
          end else begin
            state_d      = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (bus_ack) begin
          // Ack has priority over a timeout landing in the same cycle.
          load_data_d = we_q ? 32'h0 : rdata_ext;
          state_d     = ST_DONE;
        end else if (timeout_hit) begin
          load_data_d = 32'h0;
          bus_err_d   = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        // MemRead/MemWrite still belong to the finished instruction here,
        // so DONE never starts a new access.
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      lane_q       <= 2'b00;
      size_q       <= SZ_BYTE;
      unsigned_q   <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      load_data_q  <= 32'h0;
      bus_err_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      load_data_q  <= load_data_d;
      bus_err_q    <= bus_err_d;
      misaligned_q <= misaligned_d;
    end
  end

  // stall is combinational from MemRead/MemWrite in IDLE; gate it with reset
  // so every output is quiet while rst_n is low.
  assign stall      = stall_c & rst_n;
  assign load_data  = load_data_q;
  assign load_valid = (state_q == ST_DONE) && !we_q;
  assign misaligned = misaligned_q;
  assign bus_err    = bus_err_q;
  assign bus_req    = (state_q == ST_REQ);
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_wstrb  = wstrb_q;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the RISC-V core.
- Takes the ALU result as the effective address and rs2 read data as store data.
- Runs a single outstanding request/acknowledge transaction on the data-memory/MMIO bus, and stalls the core until it completes.
- Returns sign- or zero-extended load data to the write-back stage.

Parameters:
- ADDR_WIDTH, 32: bus address width; low ADDR_WIDTH bits of the effective address are used.
- TIMEOUT_CYCLES, 255: cycles REQ may wait for bus_ack before bus_err; 0 disables the timeout.

Ports:
- clk  in  1  core clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ALUResult  in  32  effective address.
- ReadData2  in  32  store data (rs2).
- MemRead  in  1  current instruction is a load.
- MemWrite  in  1  current instruction is a store.
- funct3  in  3  access size/sign.
- stall  out  1  hold PC/pipeline this cycle.
- load_data  out  32  extended load result; valid in DONE.
- load_valid  out  1  load_data valid (DONE of a load).
- misaligned  out  1  misaligned-access flag; see Optional Feature.
- bus_err  out  1  timeout flag; high in DONE only.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2],2'b00}).
- bus_wdata  out  32  lane-replicated store data.
- bus_wstrb  out  4  byte strobes; 0 on reads.
- bus_rdata  in  32  read data; sampled when bus_ack=1.
- bus_ack  in  1  one-cycle completion pulse.

Behaviour:
- Reset: state=IDLE. All outputs 0: stall, load_data, load_valid, misaligned, bus_err, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb. Timeout counter=0.
- Reset asserted mid-transaction returns to IDLE immediately. A late bus_ack after reset is ignored.
- FSM IDLE -> REQ -> DONE -> IDLE.
- IDLE:
  - start = MemRead|MemWrite. stall = start (combinational).
  - On start, register address, size, sign, direction, wdata and wstrb, then go to REQ.
  - If MemRead and MemWrite are both high, the write wins.
- REQ:
  - bus_req=1; registered bus signals held stable.
  - stall=1; counter increments every cycle.
  - On bus_ack: capture and extend bus_rdata into load_data, go to DONE.
  - Ack arriving in the first REQ cycle gives minimum latency: start -> DONE = 2 cycles.
  - If TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES with no ack: go to DONE, bus_err=1, load_data=0.
  - bus_ack and timeout in the same cycle: ack wins.
- DONE:
  - stall=0, bus_req=0; load_valid=1 for loads; held one cycle.
  - Always returns to IDLE. MemRead/MemWrite are still high for the same instruction this cycle and must not restart.
- Size decode (lane = addr[1:0]):
  - 000 byte: wstrb=0001<<lane; wdata={4{rs2[7:0]}}.
  - 001 half: wstrb=0011<<{lane[1],1'b0}; wdata={2{rs2[15:0]}}.
  - 010 word: wstrb=1111; wdata=rs2.
  - 100 byte unsigned load; 101 half unsigned load.
  - Loads select the lane, then sign-extend (000, 001) or zero-extend (100, 101).
  - 011, 110, 111 are treated as word.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0, is not issued.
  - FSM goes IDLE -> DONE directly with misaligned=1 for that DONE cycle, load_data=0, stall=1 in the IDLE cycle.
- Undefined:
  - misaligned is tied to 0.
  - Address low bits are truncated: half uses lane {addr[1],0}, word uses lane 0. Access proceeds normally.

Test Plan:
- LW addr 0x100, bus_ack on 1st REQ cycle with rdata 0xDEADBEEF -> stall high 2 cycles, DONE load_data=0xDEADBEEF, bus_wstrb=0.
- LB addr 0x103, rdata 0x80FF1234 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201, rs2=0x000000AB -> bus_we=1, bus_addr=0x200, wstrb=0010, wdata=0xABABABAB; SH addr 0x202, rs2=0x1234 -> wstrb=1100.
- TIMEOUT_CYCLES=4, no ack -> DONE after 4 REQ cycles with bus_err=1, load_data=0; then IDLE.
- rst_n low during REQ -> bus_req and stall drop immediately. After release, back-to-back SW then LW each complete with no double issue in DONE.
- With LSU_MISALIGN_TRAP_EN, LW addr 0x102 -> no bus_req, misaligned=1 for one cycle. Without it -> bus_addr=0x100, normal completion.
